// File: rtl/difftest_commit_ctrl_if.sv
// Commit handshake bundle: writeback-side push channel and difftest-bridge pop channel.
// The slave modport is the commit controller; the master modport is its environment.
interface difftest_commit_ctrl_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] wb_pc;
  logic [31:0] wb_inst;
  logic        wb_skip;
  logic        wb_ebreak;
  logic [63:0] wb_a0;
  logic        dt_valid;
  logic        dt_ready;
  logic [63:0] dt_pc;
  logic [63:0] dt_inst;
  logic        dt_skip;

  modport master (
    output wb_valid, wb_pc, wb_inst, wb_skip, wb_ebreak, wb_a0, dt_ready,
    input  wb_ready, dt_valid, dt_pc, dt_inst, dt_skip
  );

  modport slave (
    input  wb_valid, wb_pc, wb_inst, wb_skip, wb_ebreak, wb_a0, dt_ready,
    output wb_ready, dt_valid, dt_pc, dt_inst, dt_skip
  );
endinterface

// File: rtl/difftest_commit_ctrl.sv
// Retired-instruction sequencer between WB and the difftest bridge: commit FIFO,
// ebreak drain/halt with good/bad trap, and a no-commit watchdog.
module difftest_commit_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 10000
) (
  input  logic                   clk,
  input  logic                   rst,
  difftest_commit_ctrl_if.slave  bus,
  output logic [63:0]            commit_cnt,
  output logic                   halt,
  output logic                   good_trap,
  output logic                   hang
);

  localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
  localparam bit             WD_EN    = (TIMEOUT != 0);
  localparam logic [31:0]    TO_LAST  = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALT, HANG} state_t;

  state_t          state, state_nxt;
  logic [63:0]     pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic            skip_mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [31:0]     idle_cnt;
  logic            a0_zero;

  logic            full, empty, active, accept, deq, timeout_hit;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign active = (state == RUN) || (state == DRAIN);
  assign accept = bus.wb_valid && bus.wb_ready;
  assign deq    = bus.dt_valid && bus.dt_ready;
  // Expiry is suppressed by a same-cycle dequeue, which would have cleared the counter.
  assign timeout_hit = WD_EN && active && (idle_cnt == TO_LAST) && !deq;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Hang takes priority over both the ebreak transition and the halt transition.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (timeout_hit)                    state_nxt = HANG;
        else if (accept && bus.wb_ebreak)   state_nxt = DRAIN;
      end
      DRAIN: begin
        if (timeout_hit)                    state_nxt = HANG;
        else if (empty && !accept)          state_nxt = HALT;
      end
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    bus.wb_ready = (state == RUN) && !full;
    bus.dt_valid = !empty && active;
    bus.dt_pc    = empty ? 64'd0 : pc_mem[rd_ptr];
    bus.dt_inst  = empty ? 64'd0 : {32'd0, inst_mem[rd_ptr]};
    bus.dt_skip  = empty ? 1'b0  : skip_mem[rd_ptr];
    halt         = (state == HALT);
    hang         = (state == HANG);
    good_trap    = (state == HALT) && a0_zero;
  end

  // Storage is data only; validity comes from count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_mem[wr_ptr]   <= bus.wb_pc;
      inst_mem[wr_ptr] <= bus.wb_inst;
      skip_mem[wr_ptr] <= bus.wb_skip;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      commit_cnt <= '0;
      idle_cnt   <= '0;
      a0_zero    <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (deq)    rd_ptr <= rd_ptr + AW'(1);
      if (accept && !deq)      count <= count + (AW+1)'(1);
      else if (!accept && deq) count <= count - (AW+1)'(1);
      if (deq) commit_cnt <= commit_cnt + 64'd1;
      if (deq)         idle_cnt <= '0;
      else if (active) idle_cnt <= idle_cnt + 32'd1;
      if (accept && bus.wb_ebreak && (state == RUN)) a0_zero <= (bus.wb_a0 == 64'd0);
    end
  end

endmodule

// File: tb/tb_difftest_commit_ctrl.sv
// Directed bench for difftest_commit_ctrl: per-cycle vector table plus hand sequences
// for wrap, bad trap, watchdog expiry and reset during drain.
module tb_difftest_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] commit_cnt;
  logic        halt, good_trap, hang;

  difftest_commit_ctrl_if bus ();

  difftest_commit_ctrl #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .commit_cnt (commit_cnt),
    .halt       (halt),
    .good_trap  (good_trap),
    .hang       (hang)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        skip;
    logic        eb;
    logic [63:0] a0;
    logic        dr;
    logic        e_wr;
    logic        e_dv;
    logic [63:0] e_pc;
    logic [63:0] e_inst;
    logic        e_skip;
    logic [63:0] e_cnt;
    logic        e_halt;
    logic        e_good;
    logic        e_hang;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input int wv, input longint unsigned pc, input int unsigned inst,
                              input int skip, input int eb, input longint unsigned a0, input int dr,
                              input int e_wr, input int e_dv, input longint unsigned e_pc,
                              input longint unsigned e_inst, input int e_skip,
                              input longint unsigned e_cnt, input int e_halt, input int e_good,
                              input int e_hang);
    vec_t v;
    v.wv = wv[0];     v.pc = pc;         v.inst = inst;     v.skip = skip[0];
    v.eb = eb[0];     v.a0 = a0;         v.dr = dr[0];
    v.e_wr = e_wr[0]; v.e_dv = e_dv[0];  v.e_pc = e_pc;     v.e_inst = e_inst;
    v.e_skip = e_skip[0]; v.e_cnt = e_cnt; v.e_halt = e_halt[0];
    v.e_good = e_good[0]; v.e_hang = e_hang[0];
    return v;
  endfunction

  task automatic set_in(input int wv, input longint unsigned pc, input int unsigned inst,
                        input int skip, input int eb, input longint unsigned a0, input int dr);
    bus.wb_valid  = wv[0];
    bus.wb_pc     = pc;
    bus.wb_inst   = inst;
    bus.wb_skip   = skip[0];
    bus.wb_ebreak = eb[0];
    bus.wb_a0     = a0;
    bus.dt_ready  = dr[0];
  endtask

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  initial begin
    // single commit
    tbl[0]  = mk(1, 'h80000000, 'h413, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0,  0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 1,  1, 1, 'h80000000, 'h413, 0, 0,  0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 1,  0, 0, 0);
    // backpressure until full, then drain in order with the fifth accepted late
    tbl[3]  = mk(1, 'h100, 'h11, 1, 0, 0, 0,  1, 0, 0, 0, 0, 1,  0, 0, 0);
    tbl[4]  = mk(1, 'h104, 'h12, 0, 0, 0, 0,  1, 1, 'h100, 'h11, 1, 1,  0, 0, 0);
    tbl[5]  = mk(1, 'h108, 'h13, 1, 0, 0, 0,  1, 1, 'h100, 'h11, 1, 1,  0, 0, 0);
    tbl[6]  = mk(1, 'h10c, 'h14, 0, 0, 0, 0,  1, 1, 'h100, 'h11, 1, 1,  0, 0, 0);
    tbl[7]  = mk(1, 'h110, 'h15, 1, 0, 0, 0,  0, 1, 'h100, 'h11, 1, 1,  0, 0, 0);
    tbl[8]  = mk(1, 'h110, 'h15, 1, 0, 0, 1,  0, 1, 'h100, 'h11, 1, 1,  0, 0, 0);
    tbl[9]  = mk(1, 'h110, 'h15, 1, 0, 0, 1,  1, 1, 'h104, 'h12, 0, 2,  0, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 1,  1, 1, 'h108, 'h13, 1, 3,  0, 0, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 1,  1, 1, 'h10c, 'h14, 0, 4,  0, 0, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 1,  1, 1, 'h110, 'h15, 1, 5,  0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 6,  0, 0, 0);
    // good trap: ebreak behind two pending commits
    tbl[14] = mk(1, 'h200, 'h21, 0, 0, 0, 0,  1, 0, 0, 0, 0, 6,  0, 0, 0);
    tbl[15] = mk(1, 'h204, 'h22, 0, 0, 0, 0,  1, 1, 'h200, 'h21, 0, 6,  0, 0, 0);
    tbl[16] = mk(1, 'h208, 'h00100073, 0, 1, 0, 0,  1, 1, 'h200, 'h21, 0, 6,  0, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 1,  0, 1, 'h200, 'h21, 0, 6,  0, 0, 0);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 1,  0, 1, 'h204, 'h22, 0, 7,  0, 0, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 1,  0, 1, 'h208, 'h00100073, 0, 8,  0, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 9,  0, 0, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 9,  1, 1, 0);
    tbl[22] = mk(1, 'h20c, 'h13, 0, 0, 0, 1,  0, 0, 0, 0, 0, 9,  1, 1, 0);

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    do_reset();

    for (int i = 0; i < NV; i++) begin
      set_in(32'(tbl[i].wv), tbl[i].pc, tbl[i].inst, 32'(tbl[i].skip), 32'(tbl[i].eb),
             tbl[i].a0, 32'(tbl[i].dr));
      #1;
      n_vec++;
      if ({bus.wb_ready, bus.dt_valid, bus.dt_pc, bus.dt_inst, bus.dt_skip, commit_cnt,
           halt, good_trap, hang} !==
          {tbl[i].e_wr, tbl[i].e_dv, tbl[i].e_pc, tbl[i].e_inst, tbl[i].e_skip, tbl[i].e_cnt,
           tbl[i].e_halt, tbl[i].e_good, tbl[i].e_hang}) begin
        n_bad++;
        $display("FAIL vec%0d: got wr=%b dv=%b pc=%h inst=%h skip=%b cnt=%0d halt=%b good=%b hang=%b; want wr=%b dv=%b pc=%h inst=%h skip=%b cnt=%0d halt=%b good=%b hang=%b",
                 i, bus.wb_ready, bus.dt_valid, bus.dt_pc, bus.dt_inst, bus.dt_skip, commit_cnt,
                 halt, good_trap, hang, tbl[i].e_wr, tbl[i].e_dv, tbl[i].e_pc, tbl[i].e_inst,
                 tbl[i].e_skip, tbl[i].e_cnt, tbl[i].e_halt, tbl[i].e_good, tbl[i].e_hang);
      end
      nxt();
    end

    // 20 back-to-back commits with simultaneous push/pop across pointer wrap
    do_reset();
    for (int i = 0; i <= 20; i++) begin
      set_in((i < 20) ? 1 : 0, 64'h1000 + 64'(4 * i), 32'(i), 0, 0, 0, 1);
      #1;
      if (i > 0)
        chk($sformatf("wrap%0d", i), {62'd0, bus.wb_ready, bus.dt_valid} ^ bus.dt_pc,
            {62'd0, 2'b11} ^ (64'h1000 + 64'(4 * (i - 1))));
      nxt();
    end
    chk("wrap_cnt", commit_cnt, 64'd20);
    chk("wrap_empty", {63'd0, bus.dt_valid}, 64'd0);

    // bad trap: ebreak with a0=1
    do_reset();
    set_in(1, 'h300, 'h00100073, 0, 1, 1, 1);
    nxt();
    set_in(0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("bad_ready_dv", {62'd0, bus.wb_ready, bus.dt_valid}, 64'd1);
    chk("bad_head_pc", bus.dt_pc, 64'h300);
    nxt();
    chk("bad_pre_halt", {61'd0, bus.dt_valid, halt, good_trap}, 64'd0);
    chk("bad_cnt", commit_cnt, 64'd1);
    nxt();
    chk("bad_halt", {61'd0, halt, good_trap, hang}, 64'b100);

    // watchdog: one stalled commit, hang after exactly 8 idle cycles
    do_reset();
    set_in(1, 'h400, 'h13, 0, 0, 0, 0);
    nxt();
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk($sformatf("hang_k%0d", k), {63'd0, hang}, (k >= 8) ? 64'd1 : 64'd0);
      if (k < 8) nxt();
    end
    chk("hang_outputs", {62'd0, bus.wb_ready, bus.dt_valid}, 64'd0);

    // ebreak accepted on the expiry cycle still ends in HANG
    do_reset();
    set_in(1, 'h500, 'h13, 0, 0, 0, 0);
    nxt();
    set_in(0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k < 7; k++) nxt();
    set_in(1, 'h504, 'h00100073, 0, 1, 0, 0);
    #1;
    chk("exp_ebreak_accepted", {63'd0, bus.wb_ready}, 64'd1);
    nxt();
    set_in(0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("exp_ebreak_hang", {62'd0, hang, halt}, 64'b10);
    nxt();
    nxt();
    chk("exp_ebreak_sticky", {61'd0, hang, halt, bus.dt_valid}, 64'b100);

    // reset asserted while draining three entries
    do_reset();
    set_in(1, 'h600, 'h13, 0, 0, 0, 0);
    nxt();
    set_in(1, 'h604, 'h13, 0, 0, 0, 1);
    nxt();
    set_in(1, 'h608, 'h13, 0, 0, 0, 0);
    nxt();
    set_in(1, 'h60c, 'h00100073, 0, 1, 0, 0);
    nxt();
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("drain_state", {62'd0, bus.wb_ready, bus.dt_valid}, 64'd1);
    chk("drain_head", bus.dt_pc, 64'h604);
    chk("drain_cnt", commit_cnt, 64'd1);
    nxt();
    rst = 1'b0;
    #1;
    chk("rst_ready_dv", {62'd0, bus.wb_ready, bus.dt_valid}, 64'b10);
    chk("rst_cnt", commit_cnt, 64'd0);
    chk("rst_flags", {61'd0, halt, good_trap, hang}, 64'd0);
    chk("rst_dt_pc", bus.dt_pc, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
